// File: rtl/fpga_test_scheduler.sv
// Runs a bank of program-runner instances one at a time, with a per-test cycle timeout,
// and collects pass/timeout masks plus an aggregate verdict.
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | raise run[current]; finished ignored (may be stale)
// WAIT   | hold run, wait for finished[current] or timeout
// RECORD | fold the latched outcome into masks/count
// GAP    | run low for one cycle, advance to next test
// DONE   | results held, start restarts the batch
module fpga_test_scheduler #(
    parameter int NTests        = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic [NTests-1:0]           run,
    input  logic [NTests-1:0]           finished,
    input  logic [NTests-1:0]           success,
    output logic                        busy,
    output logic                        done,
    output logic                        allPassed,
    output logic [NTests-1:0]           passMask,
    output logic [NTests-1:0]           timeoutMask,
    output logic [$clog2(NTests+1)-1:0] passCount,
    output logic [((NTests > 1) ? $clog2(NTests) : 1)-1:0] current
);

    localparam int CW = (NTests > 1) ? $clog2(NTests) : 1;
    localparam int PW = $clog2(NTests + 1);
    localparam int TW = $clog2(TimeoutCycles);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_RECORD, S_GAP, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [TW-1:0]     timer;
    logic              out_pass;
    logic              out_timeout;
    logic [NTests-1:0] cur_bit;
    logic              fin_cur;
    logic              suc_cur;
    logic              timer_last;
    logic              last_test;

    assign fin_cur    = finished[current];
    assign suc_cur    = success[current];
    assign timer_last = (timer == TW'(TimeoutCycles - 1));
    assign last_test  = (current == CW'(NTests - 1));

    always_comb begin
        cur_bit          = '0;
        cur_bit[current] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (fin_cur || timer_last) state_nxt = S_RECORD;
            S_RECORD: state_nxt = last_test ? S_DONE : S_GAP;
            S_GAP:    state_nxt = S_LAUNCH;
            S_DONE:   if (start) state_nxt = S_LAUNCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        run  = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_LAUNCH, S_WAIT: begin
                run  = cur_bit;
                busy = 1'b1;
            end
            S_RECORD, S_GAP: busy = 1'b1;
            S_DONE:          done = 1'b1;
            default: ;
        endcase
    end

    // Outcome is latched on WAIT exit and applied in RECORD so results appear one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            current     <= '0;
            out_pass    <= 1'b0;
            out_timeout <= 1'b0;
            passMask    <= '0;
            timeoutMask <= '0;
            passCount   <= '0;
            allPassed   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        current     <= '0;
                        passMask    <= '0;
                        timeoutMask <= '0;
                        passCount   <= '0;
                        allPassed   <= 1'b0;
                    end
                end
                S_LAUNCH: timer <= '0;
                S_WAIT: begin
                    out_pass    <= fin_cur && suc_cur;
                    out_timeout <= !fin_cur;
                    if (!fin_cur && !timer_last) timer <= timer + TW'(1);
                end
                S_RECORD: begin
                    if (out_pass) begin
                        passMask[current] <= 1'b1;
                        passCount         <= passCount + PW'(1);
                    end
                    if (out_timeout) timeoutMask[current] <= 1'b1;
                    if (last_test) allPassed <= &(passMask | (out_pass ? cur_bit : '0));
                end
                S_GAP: current <= current + CW'(1);
                default: ;
            endcase
        end
    end

endmodule
